kbd_event_writer: RTL and testbench

Wishbone initiator that converts discrete key events (row, column, pressed/released) into read-modify-write updates of the keyboard matrix registers held by `keyboard`. It sits between the host-side key source (MCU/SPI bridge) and the keyboard's Wishbone responder. It also provides a "release all" sweep that restores every row to 8'hFF. Matrix bits are active-low: a pressed key is 0.

---
 rtl/kbd_event_writer_pkg.sv | 33 +++
 rtl/kbd_event_writer_wb_req.sv | 39 +++
 rtl/kbd_event_writer.sv | 148 ++++++++++++++
 tb/tb_kbd_event_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_event_writer_pkg.sv
// Shared constants and types for the keyboard event writer.
//   WB_KBD_BASE   : Wishbone address of keyboard matrix row 0
//   KBD_ROW_COUNT : number of matrix rows held by the keyboard
//   kbd_evt_t     : packed key event {row, col, pressed}
//   kbd_apply_key : active-low read-modify-write of one matrix bit
package kbd_event_writer_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned KBD_ROW_COUNT = 10;
  localparam int unsigned KBD_ROW_WIDTH = 4;
  localparam int unsigned KBD_COL_WIDTH = 3;

  localparam logic [WB_ADDR_WIDTH-1:0] WB_KBD_BASE = 16'h0040;

  typedef struct packed {
    logic [KBD_ROW_WIDTH-1:0] row;
    logic [KBD_COL_WIDTH-1:0] col;
    logic                     pressed;
  } kbd_evt_t;

  // Matrix bits are active-low: press clears the bit, release sets it.
  function automatic logic [DATA_WIDTH-1:0] kbd_apply_key(
    input logic [DATA_WIDTH-1:0]    rd,
    input logic [KBD_COL_WIDTH-1:0] col,
    input logic                     pressed
  );
    logic [DATA_WIDTH-1:0] mask;
    mask = DATA_WIDTH'(1) << col;
    return pressed ? (rd & ~mask) : (rd | mask);
  endfunction

endpackage

// File: rtl/kbd_event_writer_wb_req.sv
// Single-request Wishbone strobe/stall/ack sequencer.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a new request; strobe rises next cycle
//   wb_stall_i : responder stall, strobe is held while high
//   wb_ack_i   : responder acknowledge
//   strobe     : registered request strobe
//   accept     : strobe taken by the responder this cycle
//   done       : acknowledge for the outstanding request this cycle
module kbd_event_writer_wb_req (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic wb_stall_i,
  input  logic wb_ack_i,
  output logic strobe,
  output logic accept,
  output logic done
);

  logic active;

  assign accept = strobe & ~wb_stall_i;
  // An ack alongside the accepted strobe completes the request at once.
  assign done   = active & wb_ack_i & (~strobe | ~wb_stall_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 1'b0;
      active <= 1'b0;
    end else if (start) begin
      strobe <= 1'b1;
      active <= 1'b1;
    end else begin
      if (accept) strobe <= 1'b0;
      if (done)   active <= 1'b0;
    end
  end

endmodule

// File: rtl/kbd_event_writer.sv
// Wishbone initiator turning key events into read-modify-write updates of
// the keyboard matrix rows, plus a "release all" sweep writing 8'hFF to
// every row.
//   evt_*      : key event handshake (valid/ready) with row, col, pressed
//   clear_i    : pulse requesting a release-all sweep
//   busy_o     : transfer in progress or sweep pending
//   err_o      : pulse, an event with an out-of-range row was dropped
//   wb_*       : Wishbone initiator port (single outstanding request)
module kbd_event_writer
  import kbd_event_writer_pkg::*;
#(
  parameter logic [WB_ADDR_WIDTH-1:0] KBD_BASE = WB_KBD_BASE
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     evt_valid_i,
  output logic                     evt_ready_o,
  input  logic [KBD_ROW_WIDTH-1:0] evt_row_i,
  input  logic [KBD_COL_WIDTH-1:0] evt_col_i,
  input  logic                     evt_pressed_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  output logic                     wb_sel_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_CLR_REQ, S_CLR_WAIT
  } state_t;

  localparam logic [KBD_ROW_WIDTH-1:0] LAST_ROW = KBD_ROW_WIDTH'(KBD_ROW_COUNT - 1);

  state_t   state;
  kbd_evt_t evt_q;
  logic     clr_pend;
  logic     clr_go;
  logic     row_ok;
  logic     req_start;
  logic     req_accept;
  logic     req_done;

  assign clr_go      = clr_pend | clear_i;
  assign row_ok      = evt_row_i < KBD_ROW_WIDTH'(KBD_ROW_COUNT);
  assign evt_ready_o = ~wb_reset_i & (state == S_IDLE) & ~clr_go;
  assign busy_o      = (state != S_IDLE) | clr_pend;
  assign wb_sel_o    = wb_cycle_o;
  // evt_q.row doubles as the sweep row counter during a clear.
  assign wb_addr_o   = wb_cycle_o ? KBD_BASE + WB_ADDR_WIDTH'(evt_q.row) : '0;

  always_comb begin
    req_start = 1'b0;
    unique case (state)
      S_IDLE:                 req_start = clr_go | (evt_valid_i & evt_ready_o & row_ok);
      S_RD_REQ, S_RD_WAIT:    req_start = req_done;
      S_CLR_REQ, S_CLR_WAIT:  req_start = req_done & (evt_q.row != LAST_ROW);
      default:                req_start = 1'b0;
    endcase
  end

  kbd_event_writer_wb_req u_wb_req (
    .clk        (wb_clock_i),
    .rst        (wb_reset_i),
    .start      (req_start),
    .wb_stall_i (wb_stall_i),
    .wb_ack_i   (wb_ack_i),
    .strobe     (wb_strobe_o),
    .accept     (req_accept),
    .done       (req_done)
  );

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state      <= S_IDLE;
      evt_q      <= '0;
      clr_pend   <= 1'b0;
      err_o      <= 1'b0;
      wb_cycle_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_data_o  <= '0;
    end else begin
      err_o <= 1'b0;
      if (clear_i && state != S_IDLE) clr_pend <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (clr_go) begin
            clr_pend   <= 1'b0;
            evt_q.row  <= '0;
            wb_cycle_o <= 1'b1;
            wb_we_o    <= 1'b1;
            wb_data_o  <= '1;
            state      <= S_CLR_REQ;
          end else if (evt_valid_i) begin
            if (row_ok) begin
              evt_q      <= '{row: evt_row_i, col: evt_col_i, pressed: evt_pressed_i};
              wb_cycle_o <= 1'b1;
              wb_we_o    <= 1'b0;
              state      <= S_RD_REQ;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (req_done) begin
            wb_data_o <= kbd_apply_key(wb_data_i, evt_q.col, evt_q.pressed);
            wb_we_o   <= 1'b1;
            state     <= S_WR_REQ;
          end else if (req_accept) begin
            state <= S_RD_WAIT;
          end
        end
        S_WR_REQ, S_WR_WAIT: begin
          if (req_done) begin
            wb_cycle_o <= 1'b0;
            wb_we_o    <= 1'b0;
            state      <= S_IDLE;
          end else if (req_accept) begin
            state <= S_WR_WAIT;
          end
        end
        S_CLR_REQ, S_CLR_WAIT: begin
          if (req_done) begin
            if (evt_q.row == LAST_ROW) begin
              wb_cycle_o <= 1'b0;
              wb_we_o    <= 1'b0;
              state      <= S_IDLE;
            end else begin
              evt_q.row <= evt_q.row + 1'b1;
              state     <= S_CLR_REQ;
            end
          end else if (req_accept) begin
            state <= S_CLR_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_writer.sv
module tb_kbd_event_writer;
  import kbd_event_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic [3:0]  evt_row = '0;
  logic [2:0]  evt_col = '0;
  logic        evt_pressed = 1'b0;
  logic        clear = 1'b0;
  logic        busy, err;
  logic [15:0] wb_addr;
  logic [7:0]  wb_dout;
  logic [7:0]  wb_din = '0;
  logic        wb_we, wb_cyc, wb_stb, wb_sel, wb_stall;
  logic        wb_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kbd_event_writer #(.KBD_BASE(WB_KBD_BASE)) dut (
    .wb_clock_i    (clk),
    .wb_reset_i    (rst),
    .evt_valid_i   (evt_valid),
    .evt_ready_o   (evt_ready),
    .evt_row_i     (evt_row),
    .evt_col_i     (evt_col),
    .evt_pressed_i (evt_pressed),
    .clear_i       (clear),
    .busy_o        (busy),
    .err_o         (err),
    .wb_addr_o     (wb_addr),
    .wb_data_o     (wb_dout),
    .wb_data_i     (wb_din),
    .wb_we_o       (wb_we),
    .wb_cycle_o    (wb_cyc),
    .wb_strobe_o   (wb_stb),
    .wb_sel_o      (wb_sel),
    .wb_stall_i    (wb_stall),
    .wb_ack_i      (wb_ack)
  );

  // Keyboard responder model: 16 rows, configurable stall, ack next cycle.
  logic [7:0]  mem [16];
  bit          mem_init = 1'b0;
  int unsigned stall_cfg = 0;
  int unsigned stall_left = 0;
  int          xfers = 0;
  logic [15:0] off;

  assign off      = wb_addr - WB_KBD_BASE;
  assign wb_stall = wb_cyc & wb_stb & (stall_left != 0);

  always @(posedge clk) begin
    wb_ack <= 1'b0;
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
      mem_init <= 1'b1;
    end
    if (wb_cyc && wb_stb) begin
      if (stall_left != 0) begin
        stall_left <= stall_left - 1;
      end else begin
        wb_ack     <= 1'b1;
        xfers      <= xfers + 1;
        stall_left <= stall_cfg;
        if (off < 16) begin
          if (wb_we) mem[off[3:0]] <= wb_dout;
          wb_din <= mem[off[3:0]];
        end
      end
    end else begin
      stall_left <= stall_cfg;
    end
  end

  // Bus monitor: cycle rises, strobe run lengths, stability while stalled.
  logic        prev_cyc = 1'b0;
  int          cyc_rises = 0, err_cnt = 0, runs = 0, run4 = 0, viol = 0, run = 0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_data = '0;
  logic        p_we = 1'b0;

  always @(posedge clk) begin
    prev_cyc <= wb_cyc;
    if (wb_cyc && !prev_cyc) cyc_rises <= cyc_rises + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (wb_stb) begin
      if (run != 0 && (wb_addr != p_addr || wb_dout != p_data || wb_we != p_we))
        viol <= viol + 1;
      run    <= run + 1;
      p_addr <= wb_addr;
      p_data <= wb_dout;
      p_we   <= wb_we;
    end else if (run != 0) begin
      runs <= runs + 1;
      if (run == 4) run4 <= run4 + 1;
      run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_rows(input string tag, input logic [7:0] r3, input logic [7:0] r0,
                            input logic [7:0] r9);
    int nbad = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i == 3) ? r3 : (i == 0) ? r0 : (i == 9) ? r9 : 8'hFF;
      if (mem[i] !== e) nbad++;
    end
    chk(tag, nbad, 0);
  endtask

  // Leaves the bench at the negedge of the cycle after acceptance.
  task automatic send_evt(input logic [3:0] r, input logic [2:0] c, input logic p);
    bit done = 1'b0;
    @(negedge clk);
    evt_row = r; evt_col = c; evt_pressed = p; evt_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (evt_ready) done = 1'b1;
      @(negedge clk);
    end
    evt_valid = 1'b0;
    if (!done) chk("evt_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((busy || !evt_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("idle_timeout", 0, 1);
  endtask

  int n, snap_rises, snap_err, snap_runs, snap_run4, snap_xfers;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_ready", evt_ready, 0);
    chk("rst_cyc", wb_cyc, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", evt_ready, 1);
    chk("post_rst_outs", {busy, err, wb_stb, wb_sel, wb_we}, 0);

    // Press (3,2) with cycle-accurate timing
    snap_rises = cyc_rises;
    @(negedge clk);
    evt_row = 4'd3; evt_col = 3'd2; evt_pressed = 1'b1; evt_valid = 1'b1;
    chk("t1_ready_T", evt_ready, 1);
    @(negedge clk); evt_valid = 1'b0;
    chk("t1_rd_req", {wb_cyc, wb_stb, wb_we, wb_sel}, 4'b1101);
    chk("t1_rd_addr", wb_addr, WB_KBD_BASE + 16'd3);
    chk("t1_ready_busy", {evt_ready, busy}, 2'b01);
    @(negedge clk);
    chk("t1_rd_wait", {wb_cyc, wb_stb}, 2'b10);
    @(negedge clk);
    chk("t1_wr_req", {wb_cyc, wb_stb, wb_we}, 3'b111);
    chk("t1_wr_data", wb_dout, 8'hFB);
    @(negedge clk);
    chk("t1_wr_wait", {wb_cyc, wb_stb}, 2'b10);
    @(negedge clk);
    chk("t1_ready_T5", {evt_ready, wb_cyc, busy}, 3'b100);
    chk("t1_row3", mem[3], 8'hFB);
    chk("t1_one_cycle", cyc_rises - snap_rises, 1);

    // Press (3,7), release (3,2), repeat press (3,7)
    send_evt(4'd3, 3'd7, 1'b1); wait_idle(n);
    send_evt(4'd3, 3'd2, 1'b0); wait_idle(n);
    check_rows("t2_rows", 8'h7F, 8'hFF, 8'hFF);
    send_evt(4'd3, 3'd7, 1'b1); wait_idle(n);
    chk("t2_repress", mem[3], 8'h7F);

    // Out-of-range row
    snap_rises = cyc_rises; snap_err = err_cnt; snap_xfers = xfers;
    send_evt(4'd10, 3'd0, 1'b1);
    chk("t3_err_pulse", err, 1);
    @(negedge clk);
    chk("t3_err_drop", err, 0);
    wait_idle(n);
    chk("t3_err_count", err_cnt - snap_err, 1);
    chk("t3_no_bus", {cyc_rises - snap_rises, xfers - snap_xfers}, 0);
    check_rows("t3_rows", 8'h7F, 8'hFF, 8'hFF);

    // Stalling responder: 3 stall cycles per request
    stall_cfg = 3;
    @(negedge clk);
    snap_runs = runs; snap_run4 = run4;
    send_evt(4'd3, 3'd0, 1'b1); wait_idle(n);
    @(negedge clk);
    chk("t4_row3", mem[3], 8'h7E);
    chk("t4_runs", runs - snap_runs, 2);
    chk("t4_run4", run4 - snap_run4, 2);
    chk("t4_stable", viol, 0);
    stall_cfg = 0;
    @(negedge clk); @(negedge clk);

    // Rows 0 and 9, then clear sweep timing
    send_evt(4'd0, 3'd0, 1'b1); wait_idle(n);
    send_evt(4'd9, 3'd1, 1'b1); wait_idle(n);
    check_rows("t5_pre", 8'h7E, 8'hFE, 8'hFD);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n = 1;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("t5_sweep_len", n, 2 * KBD_ROW_COUNT + 1);
    check_rows("t5_cleared", 8'hFF, 8'hFF, 8'hFF);

    // Second clear during sweep: exactly one more sweep
    send_evt(4'd2, 3'd3, 1'b1); wait_idle(n);
    chk("t5b_row2", mem[2], 8'hF7);
    snap_rises = cyc_rises; snap_xfers = xfers;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0;
    wait_idle(n);
    @(negedge clk);
    chk("t5b_xfers", xfers - snap_xfers, 2 * KBD_ROW_COUNT);
    chk("t5b_cycles", cyc_rises - snap_rises, 2);
    chk("t5b_row2_clr", mem[2], 8'hFF);

    // Reset during RD_WAIT
    send_evt(4'd4, 3'd1, 1'b1);
    @(negedge clk);
    chk("t6_in_rd_wait", {wb_cyc, wb_stb, wb_we}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_abandon", {wb_cyc, wb_stb, evt_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready_back", {evt_ready, busy}, 2'b10);
    chk("t6_row4", mem[4], 8'hFF);
    send_evt(4'd1, 3'd0, 1'b1); wait_idle(n);
    chk("t6_row1", mem[1], 8'hFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 want=1");
    $fatal(1, "timeout");
  end

endmodule
